// File: rtl/washer_plant_responder.sv
// Plant/sensor responder for the washing machine controller: models tub level,
// detergent dispenser and wash/spin timers, and returns the sensor handshakes.
module washer_plant_responder #(
  parameter int FILL_LEVEL  = 8,
  parameter int DET_CYCLES  = 3,
  parameter int WASH_CYCLES = 16,
  parameter int SPIN_CYCLES = 10,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fill_value_on,
  input  logic             drain_value_on,
  input  logic             motor_on,
  input  logic             door_lock,
  input  logic             soap_wash,
  input  logic             water_wash,
  input  logic             done,
  output logic             water_filled,
  output logic             detergent_added,
  output logic             cycle_timeout,
  output logic             drained,
  output logic             spin_timeout,
  output logic [CNT_W-1:0] level,
  output logic             fault
);

  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(FILL_LEVEL);
  localparam logic [CNT_W-1:0] DET_MAX  = CNT_W'(DET_CYCLES);
  localparam logic [CNT_W-1:0] WASH_MAX = CNT_W'(WASH_CYCLES);
  localparam logic [CNT_W-1:0] SPIN_MAX = CNT_W'(SPIN_CYCLES);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] level_q,    level_d;
  logic [CNT_W-1:0] det_cnt_q,  det_cnt_d;
  logic [CNT_W-1:0] cyc_cnt_q,  cyc_cnt_d;
  logic [CNT_W-1:0] spin_cnt_q, spin_cnt_d;
  logic             det_done_q, det_done_d;
  logic             drained_q,  drained_d;
  logic             fault_q,    fault_d;

  logic dispense_req;
  logic tub_empty;
  logic det_clear;

  assign tub_empty    = (level_q == '0);
  assign det_clear    = done | ~door_lock;
  assign dispense_req = door_lock & soap_wash & ~water_wash & ~fill_value_on
                      & ~motor_on & ~drain_value_on;

  // Tub level
  always_comb begin
    level_d = level_q;
    if (fill_value_on && !drain_value_on) begin
      if (level_q < FILL_MAX) level_d = level_q + ONE;
    end else if (drain_value_on && !fill_value_on) begin
      if (level_q != '0) level_d = level_q - ONE;
    end
  end

  // Dispenser: the counter runs only on an unbroken request streak, so the
  // single-cycle request seen between fill and add-detergent never dispenses.
  always_comb begin
    det_cnt_d  = det_cnt_q;
    det_done_d = det_done_q;
    if (det_clear) begin
      det_cnt_d  = '0;
      det_done_d = 1'b0;
    end else if (dispense_req) begin
      if (det_cnt_q < DET_MAX) det_cnt_d = det_cnt_q + ONE;
      if (det_cnt_d == DET_MAX) det_done_d = 1'b1;
    end else begin
      det_cnt_d = '0;
    end
  end

  // Agitation and spin timers
  always_comb begin
    cyc_cnt_d = '0;
    if (motor_on) begin
      cyc_cnt_d = (cyc_cnt_q < WASH_MAX) ? cyc_cnt_q + ONE : cyc_cnt_q;
    end
    spin_cnt_d = '0;
    if (drain_value_on && tub_empty) begin
      spin_cnt_d = (spin_cnt_q < SPIN_MAX) ? spin_cnt_q + ONE : spin_cnt_q;
    end
  end

  // Fault checks use the tub state seen during the offending command.
  always_comb begin
    fault_d = fault_q;
    if (fill_value_on && drain_value_on) fault_d = 1'b1;
    if (motor_on && tub_empty)           fault_d = 1'b1;
    if (!door_lock && !tub_empty)        fault_d = 1'b1;
  end

  assign drained_d = (level_d == '0) & drain_value_on;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q    <= '0;
      det_cnt_q  <= '0;
      cyc_cnt_q  <= '0;
      spin_cnt_q <= '0;
      det_done_q <= 1'b0;
      drained_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      level_q    <= level_d;
      det_cnt_q  <= det_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      spin_cnt_q <= spin_cnt_d;
      det_done_q <= det_done_d;
      drained_q  <= drained_d;
      fault_q    <= fault_d;
    end
  end

  assign level           = level_q;
  assign water_filled    = (level_q == FILL_MAX);
  assign detergent_added = det_done_q;
  assign cycle_timeout   = (cyc_cnt_q == WASH_MAX);
  assign drained         = drained_q;
  assign spin_timeout    = (spin_cnt_q == SPIN_MAX);
  assign fault           = fault_q;

endmodule

// File: tb/tb_washer_plant_responder.sv
// Scoreboard bench for washer_plant_responder: driver pushes model predictions,
// a monitor pops and compares after every clock edge.
module tb_washer_plant_responder;

  localparam int FILL = 8;
  localparam int DET  = 3;
  localparam int WASH = 16;
  localparam int SPIN = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic fill_value_on = 1'b0, drain_value_on = 1'b0, motor_on = 1'b0;
  logic door_lock = 1'b0, soap_wash = 1'b0, water_wash = 1'b0, done = 1'b0;
  logic water_filled, detergent_added, cycle_timeout, drained, spin_timeout, fault;
  logic [7:0] level;

  washer_plant_responder #(
    .FILL_LEVEL(FILL), .DET_CYCLES(DET), .WASH_CYCLES(WASH),
    .SPIN_CYCLES(SPIN), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .fill_value_on(fill_value_on), .drain_value_on(drain_value_on),
    .motor_on(motor_on), .door_lock(door_lock), .soap_wash(soap_wash),
    .water_wash(water_wash), .done(done),
    .water_filled(water_filled), .detergent_added(detergent_added),
    .cycle_timeout(cycle_timeout), .drained(drained),
    .spin_timeout(spin_timeout), .level(level), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wf, det, cto, drn, spin, flt;
    logic [7:0] lvl;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference: run lengths of each qualifying condition, unsaturated.
  int  m_level, m_req_run, m_motor_run, m_spin_run;
  bit  m_det, m_fault;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_req_run = 0; m_motor_run = 0; m_spin_run = 0;
    m_det = 0; m_fault = 0;
  endtask

  // v = {fill, drain, motor, door, soap, water, done}
  task automatic drive(input logic [6:0] v);
    bit f, d, m, dl, s, w, dn, req;
    int old_level;
    exp_t e;
    @(negedge clk);
    {f, d, m, dl, s, w, dn} = v;
    {fill_value_on, drain_value_on, motor_on, door_lock, soap_wash, water_wash, done} = v;
    old_level = m_level;
    if ((f && d) || (m && old_level == 0) || (!dl && old_level != 0)) m_fault = 1;
    if (f && !d)      m_level = (old_level + 1 > FILL) ? FILL : old_level + 1;
    else if (d && !f) m_level = (old_level == 0) ? 0 : old_level - 1;
    req = dl && s && !w && !f && !m && !d;
    if (dn || !dl) begin
      m_req_run = 0; m_det = 0;
    end else if (req) begin
      m_req_run++;
      if (m_req_run >= DET) m_det = 1;
    end else m_req_run = 0;
    m_motor_run = m ? m_motor_run + 1 : 0;
    m_spin_run  = (d && old_level == 0) ? m_spin_run + 1 : 0;
    e.lvl  = 8'(m_level);
    e.wf   = (m_level == FILL);
    e.det  = m_det;
    e.cto  = (m_motor_run >= WASH);
    e.drn  = (m_level == 0) && d;
    e.spin = (m_spin_run >= SPIN);
    e.flt  = m_fault;
    sb.push_back(e);
  endtask

  task automatic drive_n(input logic [6:0] v, input int n);
    for (int i = 0; i < n; i++) drive(v);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_level"}, int'(level), 0);
    chk({tag, "_water_filled"}, int'(water_filled), 0);
    chk({tag, "_det"}, int'(detergent_added), 0);
    chk({tag, "_cto"}, int'(cycle_timeout), 0);
    chk({tag, "_drained"}, int'(drained), 0);
    chk({tag, "_spin"}, int'(spin_timeout), 0);
    chk({tag, "_fault"}, int'(fault), 0);
  endtask

  // Asserted between edges so the async clear is observed without a clock.
  task automatic apply_reset();
    @(negedge clk);
    {fill_value_on, drain_value_on, motor_on, door_lock, soap_wash, water_wash, done} = '0;
    #2 reset = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset && sb.size() > 0) begin
      e = sb.pop_front();
      chk("level", int'(level), int'(e.lvl));
      chk("water_filled", int'(water_filled), int'(e.wf));
      chk("detergent_added", int'(detergent_added), int'(e.det));
      chk("cycle_timeout", int'(cycle_timeout), int'(e.cto));
      chk("drained", int'(drained), int'(e.drn));
      chk("spin_timeout", int'(spin_timeout), int'(e.spin));
      chk("fault", int'(fault), int'(e.flt));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] v;
    model_reset();
    #3 check_zero("power_on");
    @(negedge clk);
    reset = 1'b1;

    // Full wash as the controller sequences it
    drive_n(7'b1001100, FILL);      // fill with soap phase
    drive_n(7'b0001100, DET);       // dispense
    drive_n(7'b0011100, WASH);      // agitate
    drive_n(7'b0101100, FILL);      // drain to empty
    drive_n(7'b1001010, FILL);      // rinse fill
    drive_n(7'b0011010, WASH);      // rinse agitate
    drive_n(7'b0101010, FILL + SPIN); // drain and spin
    drive(7'b0001001);              // done
    drive_n(7'b0000000, 2);

    // Fill/drain overlap at level 4
    apply_reset();
    drive_n(7'b1001000, 4);
    drive_n(7'b1101000, 3);
    drive_n(7'b0001000, 3);

    // Transient dispense request then agitation
    apply_reset();
    drive_n(7'b1001100, 3);
    drive(7'b0001100);
    drive_n(7'b0011100, 4);

    // Empty agitation
    apply_reset();
    drive_n(7'b0011000, 2);

    // Door open with water in tub
    apply_reset();
    drive_n(7'b1001000, 5);
    drive_n(7'b0000000, 2);

    // Reset mid-fill, then full refill from empty
    apply_reset();
    drive_n(7'b1001000, 5);
    apply_reset();
    drive_n(7'b1001000, FILL + 1);

    // Timer saturation and clears
    apply_reset();
    drive_n(7'b1001100, FILL);
    drive_n(7'b0001100, DET + 2);
    drive_n(7'b0011100, 30);
    drive_n(7'b0001000, 2);
    drive(7'b0001101);
    drive_n(7'b0001000, 2);

    // Randomised plant traffic
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) apply_reset();
      v[6] = ($urandom_range(0, 2) == 0);
      v[5] = ($urandom_range(0, 3) == 0);
      v[4] = ($urandom_range(0, 3) == 0);
      v[3] = ($urandom_range(0, 9) != 0);
      v[2] = ($urandom_range(0, 1) == 0);
      v[1] = ($urandom_range(0, 3) == 0);
      v[0] = ($urandom_range(0, 19) == 0);
      drive_n(v, $urandom_range(1, 6));
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
